bsg_demux_bitwise_stream: RTL and testbench
===========================================

BSG_DEMUX_BITWISE_STREAM -- requirements
Module: bsg_demux_bitwise_stream

Interface
REQ-001 SHALL have parameter width_p, default 16: bit width of data_i, sel_i and each output word.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port v_i, input, 1: input beat valid.
REQ-005 SHALL have port data_i, input, width_p: input data word.
REQ-006 SHALL have port sel_i, input, width_p: per-bit route (0 -> channel 0, 1 -> channel 1).
REQ-007 SHALL have port ready_o, output, 1: the block accepts a beat this cycle.
REQ-008 SHALL have ports v0_o/v1_o, output, 1 each: channel head valid.
REQ-009 SHALL have ports data0_o/data1_o, output, width_p each: channel head data.
REQ-010 SHALL have ports mask0_o/mask1_o, output, width_p each: bits owned by that channel's head.
REQ-011 SHALL have ports pair0_o/pair1_o, output, 1 each: the head beat was also sent to the other channel.
REQ-012 SHALL have ports yumi0_i/yumi1_i, input, 1 each: consumer takes the channel head this cycle.

Function
REQ-013 SHALL accept a beat exactly when v_i and ready_o are both 1.
REQ-014 SHALL drive ready_o = neither channel FIFO FULL, independent of v_i and sel_i.
REQ-015 SHALL compute m1 = sel_i and m0 = ~sel_i for every accepted beat.
REQ-016 SHALL compute d0 = data_i & m0 and d1 = data_i & m1, bitwise, with no width change.
REQ-017 SHALL enqueue into channel k only when m_k is nonzero; all-zero sel_i targets only channel 0, all-ones sel_i targets only channel 1.
REQ-018 SHALL enqueue pair = (m0 != 0) & (m1 != 0) with each enqueued entry.
REQ-019 SHALL give each channel a 2-entry FIFO with states EMPTY, ONE and FULL.
REQ-020 SHALL transition each channel FIFO as follows: EMPTY+enq->ONE; ONE+enq-deq->FULL; ONE+deq-enq->EMPTY; ONE+enq+deq->ONE; FULL+deq->ONE. No enqueue occurs in FULL (REQ-014).
REQ-021 SHALL present an accepted beat on v_k_o in the cycle after acceptance, for one cycle of latency and no combinational path from inputs to outputs.
REQ-022 SHALL sustain one beat per cycle when consumers yumi every cycle.
REQ-023 SHALL preserve per-channel order (FIFO order).
REQ-024 SHALL treat yumi_k_i with v_k_o = 0 as an error: it is ignored, and a simulation assertion fires.
REQ-025 SHALL hold data_k_o, mask_k_o and pair_k_o stable while v_k_o = 1 and no yumi occurs.
REQ-026 SHALL drive data_k_o, mask_k_o and pair_k_o to 0 while v_k_o = 0.

Reset
REQ-027 SHALL, on reset_n_i low, immediately set both FIFOs EMPTY, v0_o/v1_o = 0 and all data/mask/pair outputs 0.
REQ-028 SHALL drive ready_o = 1 from the first clock after reset release.
REQ-029 SHALL discard in-flight beats on reset mid-operation, with no partial output after release.

Structure
REQ-030 SHALL place the FIFO state enum (EMPTY, ONE, FULL) and the default width constant in the shared package bsg_demux_pkg.
REQ-031 SHALL instantiate sub-module bsg_two_fifo_arn (2-entry, async active-low reset, v/ready in, v/yumi out) once per channel, with payload {pair, mask, data}.

Verification
REQ-032 SHALL cover a split beat: data_i=16'hA5C3, sel_i=16'h00FF -> next cycle data1_o=16'h00C3, mask1_o=16'h00FF, data0_o=16'hA500, mask0_o=16'hFF00, and pair0_o = pair1_o = 1.
REQ-033 SHALL cover single-channel routing: sel_i=16'h0000, data_i=16'h1234 -> only v0_o=1 with data0_o=16'h1234 and pair0_o=0; sel_i=16'hFFFF -> only v1_o rises.
REQ-034 SHALL cover backpressure: yumi1_i held 0 with 3 beats of sel_i=16'hFFFF -> ready_o=0 after 2 accepted; one yumi1_i -> ready_o=1 the next cycle; order preserved.
REQ-035 SHALL cover full throughput: 100 back-to-back beats with both yumis tied to v -> 100 beats out per channel and no ready_o deassertion.
REQ-036 SHALL cover mid-operation reset: both FIFOs FULL, reset_n_i pulsed low -> v0_o=v1_o=0 immediately, ready_o=1 after release, no stale beat emerges.
REQ-037 SHALL cover a spurious yumi0_i with v0_o=0 -> the assertion fires and state is unchanged.

Source files
------------

// File: rtl/bsg_demux_bitwise_stream_pkg.sv
// Shared types and constants for the bitwise stream demux and its channel FIFOs.
package bsg_demux_pkg;

  localparam int DEMUX_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/bsg_demux_bitwise_stream_if.sv
// Channel head bundle: one FIFO head as seen by its consumer.
// Handshake: the head is offered while v=1; yumi=1 in a cycle with v=1 takes it at
// the next rising edge. yumi with v=0 is illegal and ignored. state is debug only.
interface bsg_demux_bitwise_stream_if
  import bsg_demux_pkg::*;
#(
  parameter int width_p = DEMUX_WIDTH
) ();

  logic               v;
  logic               pair;
  logic [width_p-1:0] mask;
  logic [width_p-1:0] data;
  logic               yumi;
  fifo_state_e        state;

  modport master (output v, pair, mask, data, state, input yumi);
  modport slave  (input v, pair, mask, data, state, output yumi);

endinterface

// File: rtl/bsg_demux_bitwise_stream_fifo.sv
// Two-entry FIFO with async active-low reset: v/ready on the enqueue side,
// v/yumi on the head side; the head payload reads as zero whenever it is empty.
module bsg_two_fifo_arn
  import bsg_demux_pkg::*;
#(
  parameter int width_p = DEMUX_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  input  logic                      pair_i,
  input  logic [width_p-1:0]        mask_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  bsg_demux_bitwise_stream_if.master deq
);

  localparam int PW = 2 * width_p + 1;

  fifo_state_e   state_q, state_d;
  logic          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] mem_q [2];
  logic [PW-1:0] head;
  logic          valid, enq, pop;

  assign valid   = (state_q != EMPTY);
  assign ready_o = (state_q != FULL);
  assign enq     = v_i & ready_o;
  assign pop     = deq.yumi & valid;
  assign wptr_d  = wptr_q ^ enq;
  assign rptr_d  = rptr_q ^ pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (enq) state_d = ONE;
      ONE: begin
        if (enq && !pop)      state_d = FULL;
        else if (pop && !enq) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: the head is masked by valid, so stale words never leak.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= {pair_i, mask_i, data_i};
  end

  assign head      = valid ? mem_q[rptr_q] : '0;
  assign deq.v     = valid;
  assign deq.pair  = head[PW-1];
  assign deq.mask  = head[PW-2 -: width_p];
  assign deq.data  = head[width_p-1:0];
  assign deq.state = state_q;

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      spurious_yumi: assert (!(deq.yumi && !valid))
        else $warning("yumi while head invalid; ignored");
    end
  end

endmodule

// File: rtl/bsg_demux_bitwise_stream.sv
// Splits each input word bit-by-bit into two streams under sel_i; every channel
// that owns at least one bit gets a masked copy through its own 2-entry FIFO.
module bsg_demux_bitwise_stream
  import bsg_demux_pkg::*;
#(
  parameter int width_p = DEMUX_WIDTH
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] sel_i,
  output logic               ready_o,
  output logic               v0_o,
  output logic               v1_o,
  output logic [width_p-1:0] data0_o,
  output logic [width_p-1:0] data1_o,
  output logic [width_p-1:0] mask0_o,
  output logic [width_p-1:0] mask1_o,
  output logic               pair0_o,
  output logic               pair1_o,
  input  logic               yumi0_i,
  input  logic               yumi1_i
);

  bsg_demux_bitwise_stream_if #(.width_p(width_p)) ch0_if ();
  bsg_demux_bitwise_stream_if #(.width_p(width_p)) ch1_if ();

  logic [width_p-1:0] m0, m1;
  logic               pair, ready0, ready1, acc;

  assign m1      = sel_i;
  assign m0      = ~sel_i;
  assign pair    = (|m0) & (|m1);
  // A beat is taken only when both FIFOs have room, so a split beat is never torn.
  assign ready_o = ready0 & ready1;
  assign acc     = v_i & ready_o;

  bsg_two_fifo_arn #(.width_p(width_p)) fifo0 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (acc & (|m0)),
    .pair_i    (pair),
    .mask_i    (m0),
    .data_i    (data_i & m0),
    .ready_o   (ready0),
    .deq       (ch0_if)
  );

  bsg_two_fifo_arn #(.width_p(width_p)) fifo1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (acc & (|m1)),
    .pair_i    (pair),
    .mask_i    (m1),
    .data_i    (data_i & m1),
    .ready_o   (ready1),
    .deq       (ch1_if)
  );

  assign ch0_if.yumi = yumi0_i;
  assign ch1_if.yumi = yumi1_i;
  assign v0_o    = ch0_if.v;
  assign v1_o    = ch1_if.v;
  assign data0_o = ch0_if.data;
  assign data1_o = ch1_if.data;
  assign mask0_o = ch0_if.mask;
  assign mask1_o = ch1_if.mask;
  assign pair0_o = ch0_if.pair;
  assign pair1_o = ch1_if.pair;

endmodule

// File: tb/tb_bsg_demux_bitwise_stream.sv
// Bench for bsg_demux_bitwise_stream: directed scenarios plus a random run checked
// against per-channel queues of expected {pair, mask, data} heads.
module tb_bsg_demux_bitwise_stream;
  import bsg_demux_pkg::*;

  localparam int W  = 16;
  localparam int PW = 2 * W + 1;

  logic         clk, reset_n, v_i, ready_o;
  logic [W-1:0] data_i, sel_i;
  bsg_demux_bitwise_stream_if #(.width_p(W)) bus0 ();
  bsg_demux_bitwise_stream_if #(.width_p(W)) bus1 ();

  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  int n_cmp, n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bsg_demux_bitwise_stream #(.width_p(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
    .ready_o(ready_o), .v0_o(bus0.v), .v1_o(bus1.v), .data0_o(bus0.data), .data1_o(bus1.data),
    .mask0_o(bus0.mask), .mask1_o(bus1.mask), .pair0_o(bus0.pair), .pair1_o(bus1.pair),
    .yumi0_i(bus0.yumi), .yumi1_i(bus1.yumi)
  );

  assign bus0.state = dut.ch0_if.state;
  assign bus1.state = dut.ch1_if.state;

  function automatic logic [PW-1:0] exp_head0();
    if (exp_q0.size() == 0) return '0;
    return exp_q0[0];
  endfunction

  function automatic logic [PW-1:0] exp_head1();
    if (exp_q1.size() == 0) return '0;
    return exp_q1[0];
  endfunction

  // Drives one cycle of inputs, advances the model across the edge, returns at edge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [W-1:0] s,
                      input logic y0, input logic y1);
    logic         rdy, pair;
    logic [W-1:0] m0, m1;
    v_i = v; data_i = d; sel_i = s; bus0.yumi = y0; bus1.yumi = y1;
    rdy = (exp_q0.size() < 2) && (exp_q1.size() < 2);
    if (y0 && exp_q0.size() != 0) void'(exp_q0.pop_front());
    if (y1 && exp_q1.size() != 0) void'(exp_q1.pop_front());
    if (v && rdy) begin
      m1 = s; m0 = ~s;
      pair = (m0 != '0) && (m1 != '0);
      if (m0 != '0) exp_q0.push_back({pair, m0, d & m0});
      if (m1 != '0) exp_q1.push_back({pair, m1, d & m1});
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    v_i = 1'b0; data_i = '0; sel_i = '0; bus0.yumi = 1'b0; bus1.yumi = 1'b0;
    reset_n = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    v_i = 1'b0; data_i = '0; sel_i = '0; bus0.yumi = 1'b0; bus1.yumi = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus0.v !== 1'b0) begin n_err++; $display("FAIL reset_v0: got %b want 0", bus0.v); end
    n_cmp++; if (bus1.v !== 1'b0) begin n_err++; $display("FAIL reset_v1: got %b want 0", bus1.v); end
    n_cmp++; if ({bus0.pair, bus0.mask, bus0.data} !== '0) begin n_err++; $display("FAIL reset_head0: got %h want 0", {bus0.pair, bus0.mask, bus0.data}); end
    n_cmp++; if ({bus1.pair, bus1.mask, bus1.data} !== '0) begin n_err++; $display("FAIL reset_head1: got %h want 0", {bus1.pair, bus1.mask, bus1.data}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_split();
    step(1'b1, 16'hA5C3, 16'h00FF, 1'b0, 1'b0);
    n_cmp++; if (bus1.data !== 16'h00C3) begin n_err++; $display("FAIL split_data1: got %h want 00c3", bus1.data); end
    n_cmp++; if (bus1.mask !== 16'h00FF) begin n_err++; $display("FAIL split_mask1: got %h want 00ff", bus1.mask); end
    n_cmp++; if (bus0.data !== 16'hA500) begin n_err++; $display("FAIL split_data0: got %h want a500", bus0.data); end
    n_cmp++; if (bus0.mask !== 16'hFF00) begin n_err++; $display("FAIL split_mask0: got %h want ff00", bus0.mask); end
    n_cmp++; if ({bus0.v, bus1.v, bus0.pair, bus1.pair} !== 4'b1111) begin n_err++; $display("FAIL split_v_pair: got %b want 1111", {bus0.v, bus1.v, bus0.pair, bus1.pair}); end
    step(1'b0, '0, '0, 1'b1, 1'b1);
    n_cmp++; if ({bus0.v, bus1.v} !== 2'b00) begin n_err++; $display("FAIL split_drain_v: got %b want 00", {bus0.v, bus1.v}); end
    n_cmp++; if ({bus0.data, bus1.mask, bus0.pair} !== '0) begin n_err++; $display("FAIL split_drain_zero: got %h want 0", {bus0.data, bus1.mask, bus0.pair}); end
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    d = W'($urandom);
    step(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
    n_cmp++; if ({bus0.v, bus1.v} !== 2'b10) begin n_err++; $display("FAIL single0_v: got %b want 10", {bus0.v, bus1.v}); end
    n_cmp++; if ({bus0.pair, bus0.mask, bus0.data} !== {1'b0, 16'hFFFF, 16'h1234}) begin n_err++; $display("FAIL single0_head: got %h want 0ffff1234", {bus0.pair, bus0.mask, bus0.data}); end
    step(1'b1, d, 16'hFFFF, 1'b1, 1'b0);
    n_cmp++; if ({bus0.v, bus1.v} !== 2'b01) begin n_err++; $display("FAIL single1_v: got %b want 01", {bus0.v, bus1.v}); end
    n_cmp++; if ({bus1.pair, bus1.mask, bus1.data} !== {1'b0, 16'hFFFF, d}) begin n_err++; $display("FAIL single1_head: got %h want %h", {bus1.pair, bus1.mask, bus1.data}, {1'b0, 16'hFFFF, d}); end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++; if ({bus1.v, bus1.data} !== '0) begin n_err++; $display("FAIL single1_drain: got %h want 0", {bus1.v, bus1.data}); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    step(1'b1, a, '1, 1'b0, 1'b0);
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %b want 1", ready_o); end
    step(1'b1, b, '1, 1'b0, 1'b0);
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", ready_o); end
    step(1'b1, c, '1, 1'b0, 1'b0);
    n_cmp++; if ({ready_o, bus1.data} !== {1'b0, a}) begin n_err++; $display("FAIL bp_hold: got %h want %h", {ready_o, bus1.data}, {1'b0, a}); end
    step(1'b0, '0, '1, 1'b0, 1'b1);
    n_cmp++; if ({ready_o, bus1.data} !== {1'b1, b}) begin n_err++; $display("FAIL bp_release: got %h want %h", {ready_o, bus1.data}, {1'b1, b}); end
    step(1'b1, c, '1, 1'b0, 1'b1);
    n_cmp++; if ({bus0.v, bus1.v, bus1.data} !== {2'b01, c}) begin n_err++; $display("FAIL bp_third: got %h want %h", {bus0.v, bus1.v, bus1.data}, {2'b01, c}); end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (bus1.v !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", bus1.v); end
  endtask

  task automatic test_back_to_back();
    int got0, got1;
    logic [W-1:0] s;
    got0 = 0; got1 = 0;
    for (int i = 0; i < 100; i++) begin
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready: cycle %0d got %b want 1", i, ready_o); end
      if (bus0.v) got0++;
      if (bus1.v) got1++;
      s = W'($urandom); s[0] = 1'b0; s[1] = 1'b1;
      step(1'b1, W'($urandom), s, bus0.v, bus1.v);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus0.v) got0++;
      if (bus1.v) got1++;
      step(1'b0, '0, '0, bus0.v, bus1.v);
    end
    n_cmp++; if (got0 != 100) begin n_err++; $display("FAIL b2b_count0: got %0d want 100", got0); end
    n_cmp++; if (got1 != 100) begin n_err++; $display("FAIL b2b_count1: got %0d want 100", got1); end
  endtask

  task automatic test_random();
    logic [W-1:0] s;
    logic         y0, y1;
    for (int i = 0; i < 300; i++) begin
      n_cmp++; if (ready_o !== ((exp_q0.size() < 2) && (exp_q1.size() < 2))) begin n_err++; $display("FAIL rnd_ready: cycle %0d got %b", i, ready_o); end
      n_cmp++; if ({bus0.v, bus1.v} !== {exp_q0.size() != 0, exp_q1.size() != 0}) begin n_err++; $display("FAIL rnd_valid: cycle %0d got %b want %b", i, {bus0.v, bus1.v}, {exp_q0.size() != 0, exp_q1.size() != 0}); end
      n_cmp++; if ({bus0.pair, bus0.mask, bus0.data} !== exp_head0()) begin n_err++; $display("FAIL rnd_head0: cycle %0d got %h want %h", i, {bus0.pair, bus0.mask, bus0.data}, exp_head0()); end
      n_cmp++; if ({bus1.pair, bus1.mask, bus1.data} !== exp_head1()) begin n_err++; $display("FAIL rnd_head1: cycle %0d got %h want %h", i, {bus1.pair, bus1.mask, bus1.data}, exp_head1()); end
      case ($urandom_range(0, 3))
        0:       s = '0;
        1:       s = '1;
        default: s = W'($urandom);
      endcase
      y0 = ($urandom_range(0, 1) == 1) && (exp_q0.size() != 0);
      y1 = ($urandom_range(0, 1) == 1) && (exp_q1.size() != 0);
      step($urandom_range(0, 3) != 0, W'($urandom), s, y0, y1);
    end
  endtask

  task automatic test_spurious();
    logic [W-1:0] d, d2;
    d = W'($urandom); d2 = W'($urandom);
    apply_reset();
    step(1'b1, d, '1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++; if ({bus0.v, ready_o} !== 2'b01) begin n_err++; $display("FAIL spur_v_ready: got %b want 01", {bus0.v, ready_o}); end
    n_cmp++; if (bus0.state !== EMPTY) begin n_err++; $display("FAIL spur_state0: got %0d want %0d", bus0.state, EMPTY); end
    n_cmp++; if ({bus1.pair, bus1.mask, bus1.data} !== {1'b0, 16'hFFFF, d}) begin n_err++; $display("FAIL spur_head1: got %h want %h", {bus1.pair, bus1.mask, bus1.data}, {1'b0, 16'hFFFF, d}); end
    step(1'b1, d2, '0, 1'b0, 1'b1);
    n_cmp++; if ({bus0.v, bus1.v, bus0.pair, bus0.mask, bus0.data} !== {2'b10, 1'b0, 16'hFFFF, d2}) begin n_err++; $display("FAIL spur_after: got %h want %h", {bus0.v, bus1.v, bus0.pair, bus0.mask, bus0.data}, {2'b10, 1'b0, 16'hFFFF, d2}); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    step(1'b1, W'($urandom), 16'h0FF0, 1'b0, 1'b0);
    step(1'b1, W'($urandom), 16'h3C3C, 1'b0, 1'b0);
    n_cmp++; if ({ready_o, bus0.state, bus1.state} !== {1'b0, FULL, FULL}) begin n_err++; $display("FAIL mid_full: got %b want %b", {ready_o, bus0.state, bus1.state}, {1'b0, FULL, FULL}); end
    v_i = 1'b1; sel_i = 16'h00FF;
    #2 reset_n = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    #1;
    n_cmp++; if ({bus0.v, bus1.v} !== 2'b00) begin n_err++; $display("FAIL mid_async_v: got %b want 00", {bus0.v, bus1.v}); end
    n_cmp++; if ({bus0.data, bus0.mask, bus1.data, bus1.mask, bus0.pair, bus1.pair} !== '0) begin n_err++; $display("FAIL mid_async_heads: got nonzero head"); end
    v_i = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({ready_o, bus0.v, bus1.v} !== 3'b100) begin n_err++; $display("FAIL mid_release: got %b want 100", {ready_o, bus0.v, bus1.v}); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++; if ({bus0.v, bus1.v} !== 2'b00) begin n_err++; $display("FAIL mid_stale: cycle %0d got %b want 00", i, {bus0.v, bus1.v}); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_split();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_spurious();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
